ddr_bus_decoder: RTL and testbench
==================================

Name: ddr_bus_decoder

Overview:
- Passive monitor on the DDR command/data bus, the receiving end of the controller's command encoder.
- Decodes {CS#,RAS#,CAS#,WE#} into DDR_CMD and tracks the open row per bank.
- Rebuilds each READ/WRITE into per-beat transaction records (FILE_CMD command, bank/row/column, data, id, timestamp).
- Scoreboards compare these records against the stimulus file.

Parameters:
- RD_LAT, 3: cycles from READ command sample to first DQ beat sample (>=1).
- WR_LAT, 1: cycles from WRITE command sample to first DQ beat sample (>=1).
- BURST_LEN, 8: beats per burst access; power of two, 2..8.

Ports:
- clk  in  1  system clock; all sampling on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n  in  1 each  command pins.
- ddr_ba  in  2  bank address.
- ddr_addr  in  13  row (ACTIVATE), column [9:0] / A10 / A12 (READ/WRITE/PRECHRG).
- ddr_dq  in  16  data bus, one beat per cycle.
- pkt_valid  out  1  record valid this cycle.
- pkt_cmd  out  3  FILE_CMD: SCR, SCW, BLR or BLW.
- pkt_bank  out  2.
- pkt_row  out  13.
- pkt_col  out  10  column of this beat.
- pkt_data  out  16  sampled beat.
- pkt_last  out  1  final beat of the access.
- pkt_id  out  32  access sequence number.
- pkt_timestamp  out  32  cycle count at command sample.
- err_closed_bank, err_double_act, err_overlap  out  1 each  single-cycle error pulses.

Behaviour:
- Reset (async, reset_n=0):
  - All outputs 0.
  - Cycle counter, id counter, bank table and delay lines cleared.
  - In-flight accesses discarded; no packet emitted for them after release.
- Cycle counter: free-running 32-bit, +1 per clk, wraps 0xFFFFFFFF->0.
- Command decode, per cycle:
  - cs_n=1 or any code not in DDR_CMD: ignored. NOP_DDR: no action.
- ACTIVATE:
  - Sets open[ba]=1 and row[ba]=addr.
  - If the bank is already open: err_double_act pulse; the table is still updated.
- PRECHRG:
  - A10=1 closes all banks; otherwise closes ba.
  - Precharging a closed bank is legal.
- READ/WRITE:
  - Closed bank: err_closed_bank pulse, command dropped, id unchanged.
  - Otherwise the access is captured {cmd, ba, row[ba], col=addr[9:0], id, timestamp} and id increments.
  - cmd mapping: A12=1 gives single (SCR/SCW, 1 beat); A12=0 gives burst (BLR/BLW, BURST_LEN beats).
  - Reads enter an RD_LAT-deep delay line, writes a WR_LAT-deep one, one slot per cycle.
- Beat engine (states IDLE, BURST; counters beat_idx, beats_left):
  - A delay-line tap valid at cycle T means beat 0 is sampled from ddr_dq at T.
  - If both taps are valid at T, or beats_left>0 at T: err_overlap pulse; the new access is dropped and the current burst continues.
  - Otherwise the engine loads the access and samples beat 0 at T.
  - Back-to-back bursts are legal when the previous final beat was at T-1.
  - Beat k column = {col[9:log2 L], (col[log2 L-1:0]+k) mod L}, where L is the beat count. Sequential wrap within the aligned block; a single access uses col.
- Output timing:
  - One record per beat, registered: pkt_valid at T+k+1.
  - pkt_last on beat L-1. Row/id/timestamp are held from command time.
  - PRECHRG/ACTIVATE after the command does not alter in-flight records.
- Latency: command at C gives the first record at C+LAT+1 (LAT = RD_LAT or WR_LAT).
- Simultaneity: ACTIVATE and a column command cannot share a cycle (one bus). A table update and a delay-line emerge in the same cycle are independent.

Decomposition:
- Shared definitions package holds:
  - FILE_CMD, DDR_CMD and packet (existing).
  - New struct pending_access {valid, cmd, bank, row, col, id, timestamp}, used in both delay lines.
  - Constants A10_BIT=10, A12_BIT=12.
- Sub-module ddr_bank_tracker: open/row table per bank, ACTIVATE/PRECHRG update, row lookup, err_double_act and closed-bank detection.

Test Plan:
- Reset released, ACTIVATE ba=1 row=0x0ABC, then READ ba=1 col=0x010 A12=0 at cycle 20, dq=0x1000+k from cycle 23 -> 8 records from cycle 24: cmd=BLR, row=0x0ABC, col 0x010..0x017, data 0x1000..0x1007, id=0, timestamp=20, pkt_last on the 8th.
- WRITE col=0x00D A12=0 -> cols 0x00D,0x00E,0x00F,0x008..0x00C (wrap); WRITE with A12=1 -> one record cmd=SCW, pkt_last=1.
- READ to a never-activated bank 2 -> err_closed_bank pulse one cycle after the command, no records, next access id unchanged.
- ACTIVATE bank 0 twice -> err_double_act; PRECHRG A10=1 then READ bank 0 -> err_closed_bank.
- Two READs 8 cycles apart -> 16 contiguous records, ids 0/1. READ then WRITE 2 cycles later (both taps colliding) -> err_overlap, the write is dropped.
- reset_n low mid-burst (after beat 3) -> outputs 0 immediately, no further records; a new access afterwards starts at id 0.

Source files
------------

// File: rtl/ddr_bus_decoder_pkg.sv
// Shared definitions for the DDR bus decoder: command encodings, access and
// packet records, and small helpers used by the decoder and its bank tracker.
package ddr_bus_decoder_pkg;

  localparam int A10_BIT = 10;
  localparam int A12_BIT = 12;

  // Transaction kind carried in each record (single/burst, read/write).
  typedef enum logic [2:0] {
    FC_NONE = 3'd0,
    SCR     = 3'd1,
    SCW     = 3'd2,
    BLR     = 3'd3,
    BLW     = 3'd4
  } file_cmd_t;

  // Bus command, encoded as {CS#, RAS#, CAS#, WE#}.
  typedef enum logic [3:0] {
    DDR_PRECHRG  = 4'b0010,
    DDR_ACTIVATE = 4'b0011,
    DDR_WRITE    = 4'b0100,
    DDR_READ     = 4'b0101,
    NOP_DDR      = 4'b0111,
    DDR_IGNORED  = 4'b1111
  } ddr_cmd_t;

  typedef enum logic {
    ENG_IDLE  = 1'b0,
    ENG_BURST = 1'b1
  } beat_state_t;

  // Column access travelling through a read or write delay line.
  typedef struct packed {
    logic        valid;
    file_cmd_t   cmd;
    logic [1:0]  bank;
    logic [12:0] row;
    logic [9:0]  col;
    logic [31:0] id;
    logic [31:0] timestamp;
  } pending_access_t;

  // One per-beat transaction record.
  typedef struct packed {
    logic        valid;
    file_cmd_t   cmd;
    logic [1:0]  bank;
    logic [12:0] row;
    logic [9:0]  col;
    logic [15:0] data;
    logic        last;
    logic [31:0] id;
    logic [31:0] timestamp;
  } packet_t;

  // Map the four command pins to a bus command; anything unknown is ignored.
  function automatic ddr_cmd_t decode_cmd(input logic [3:0] pins);
    ddr_cmd_t cmd;
    case (pins)
      4'b0010: cmd = DDR_PRECHRG;
      4'b0011: cmd = DDR_ACTIVATE;
      4'b0100: cmd = DDR_WRITE;
      4'b0101: cmd = DDR_READ;
      4'b0111: cmd = NOP_DDR;
      default: cmd = DDR_IGNORED;
    endcase
    return cmd;
  endfunction

  function automatic logic is_burst(input file_cmd_t cmd);
    return (cmd == BLR) || (cmd == BLW);
  endfunction

  // Sequential wrap inside the aligned block selected by mask (mask = L-1).
  function automatic logic [9:0] beat_col(input logic [9:0] col,
                                          input logic [9:0] k,
                                          input logic [9:0] mask);
    logic [9:0] sum;
    sum = col + k;
    return (col & ~mask) | (sum & mask);
  endfunction

endpackage

// File: rtl/ddr_bus_decoder_bank_tracker.sv
// Per-bank open/row table fed by ACTIVATE and PRECHRG, with combinational
// lookup of the addressed bank for column commands.
module ddr_bank_tracker
  import ddr_bus_decoder_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        act,
  input  logic        pre,
  input  logic        pre_all,
  input  logic [1:0]  ba,
  input  logic [12:0] addr,
  output logic        bank_open,
  output logic [12:0] bank_row,
  output logic        double_act
);

  logic [3:0]       open_r;
  logic [3:0][12:0] row_r;

  // Lookup of the addressed bank; ACTIVATE to an open bank is flagged.
  always_comb begin
    bank_open  = open_r[ba];
    bank_row   = row_r[ba];
    double_act = act & open_r[ba];
  end

  // Table update: ACTIVATE opens and loads the row, PRECHRG closes one or all.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      open_r <= 4'd0;
      row_r  <= '0;
    end else if (act) begin
      open_r[ba] <= 1'b1;
      row_r[ba]  <= addr;
    end else if (pre) begin
      if (pre_all) begin
        open_r <= 4'd0;
      end else begin
        open_r[ba] <= 1'b0;
      end
    end else begin
      open_r <= open_r;
      row_r  <= row_r;
    end
  end

endmodule

// File: rtl/ddr_bus_decoder.sv
// Passive DDR bus monitor: decodes commands, tracks open rows, and rebuilds
// every READ/WRITE into registered per-beat transaction records.
module ddr_bus_decoder
  import ddr_bus_decoder_pkg::*;
#(
  parameter int RD_LAT    = 3,
  parameter int WR_LAT    = 1,
  parameter int BURST_LEN = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ddr_cs_n,
  input  logic        ddr_ras_n,
  input  logic        ddr_cas_n,
  input  logic        ddr_we_n,
  input  logic [1:0]  ddr_ba,
  input  logic [12:0] ddr_addr,
  input  logic [15:0] ddr_dq,
  output logic        pkt_valid,
  output logic [2:0]  pkt_cmd,
  output logic [1:0]  pkt_bank,
  output logic [12:0] pkt_row,
  output logic [9:0]  pkt_col,
  output logic [15:0] pkt_data,
  output logic        pkt_last,
  output logic [31:0] pkt_id,
  output logic [31:0] pkt_timestamp,
  output logic        err_closed_bank,
  output logic        err_double_act,
  output logic        err_overlap
);

  localparam logic [3:0] BURST_BEATS = 4'(BURST_LEN);
  localparam logic [9:0] BURST_MASK  = 10'(BURST_LEN - 1);

  ddr_cmd_t        cmd_s;
  logic            act_s, pre_s, rd_s, wr_s, col_cmd_s;
  logic            bank_open_s, double_act_s, closed_s;
  logic [12:0]     bank_row_s;
  pending_access_t acc_s, rd_acc_s, wr_acc_s;
  pending_access_t rd_line_r [RD_LAT];
  pending_access_t wr_line_r [WR_LAT];
  pending_access_t tap_rd_s, tap_wr_s, sel_s, cur_r, beat_acc_s;
  logic [31:0]     cycle_r, id_r;
  beat_state_t     state_r, state_s;
  logic [2:0]      beat_idx_r, beat_k_s;
  logic [3:0]      beats_left_r, load_len_s;
  logic            load_s, overlap_s, beat_v_s, beat_last_s;
  logic [9:0]      beat_mask_s;
  packet_t         pkt_s;

  // Command decode from the four command pins.
  always_comb begin
    cmd_s     = decode_cmd({ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n});
    act_s     = (cmd_s == DDR_ACTIVATE);
    pre_s     = (cmd_s == DDR_PRECHRG);
    rd_s      = (cmd_s == DDR_READ);
    wr_s      = (cmd_s == DDR_WRITE);
    col_cmd_s = rd_s | wr_s;
  end

  ddr_bank_tracker u_bank_tracker (
    .clk        (clk),
    .reset_n    (reset_n),
    .act        (act_s),
    .pre        (pre_s),
    .pre_all    (ddr_addr[A10_BIT]),
    .ba         (ddr_ba),
    .addr       (ddr_addr),
    .bank_open  (bank_open_s),
    .bank_row   (bank_row_s),
    .double_act (double_act_s)
  );

  // Build the access record for a column command to an open bank.
  always_comb begin
    acc_s           = '0;
    acc_s.valid     = col_cmd_s & bank_open_s;
    acc_s.bank      = ddr_ba;
    acc_s.row       = bank_row_s;
    acc_s.col       = ddr_addr[9:0];
    acc_s.id        = id_r;
    acc_s.timestamp = cycle_r;
    if (rd_s) begin
      if (ddr_addr[A12_BIT]) acc_s.cmd = SCR;
      else                   acc_s.cmd = BLR;
    end else begin
      if (ddr_addr[A12_BIT]) acc_s.cmd = SCW;
      else                   acc_s.cmd = BLW;
    end
    rd_acc_s       = acc_s;
    rd_acc_s.valid = acc_s.valid & rd_s;
    wr_acc_s       = acc_s;
    wr_acc_s.valid = acc_s.valid & wr_s;
    closed_s       = col_cmd_s & ~bank_open_s;
  end

  // Free-running cycle counter and access sequence number.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_r <= 32'd0;
      id_r    <= 32'd0;
    end else begin
      cycle_r <= cycle_r + 32'd1;
      if (acc_s.valid) id_r <= id_r + 32'd1;
      else             id_r <= id_r;
    end
  end

  // Read delay line: the last slot is valid on the first data beat cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RD_LAT; i++) rd_line_r[i] <= '0;
    end else begin
      rd_line_r[0] <= rd_acc_s;
      for (int i = 1; i < RD_LAT; i++) rd_line_r[i] <= rd_line_r[i-1];
    end
  end

  // Write delay line, same shape as the read line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < WR_LAT; i++) wr_line_r[i] <= '0;
    end else begin
      wr_line_r[0] <= wr_acc_s;
      for (int i = 1; i < WR_LAT; i++) wr_line_r[i] <= wr_line_r[i-1];
    end
  end

  // Beat engine next state: load a tap when idle (read wins a tie), otherwise
  // keep streaming and flag any tap that arrives while busy.
  always_comb begin
    tap_rd_s    = rd_line_r[RD_LAT-1];
    tap_wr_s    = wr_line_r[WR_LAT-1];
    state_s     = state_r;
    load_s      = 1'b0;
    overlap_s   = 1'b0;
    sel_s       = tap_rd_s;
    load_len_s  = 4'd1;
    beat_v_s    = 1'b0;
    beat_acc_s  = cur_r;
    beat_k_s    = beat_idx_r;
    beat_last_s = 1'b0;
    case (state_r)
      ENG_IDLE: begin
        if (tap_rd_s.valid) begin
          load_s    = 1'b1;
          sel_s     = tap_rd_s;
          overlap_s = tap_wr_s.valid;
        end else if (tap_wr_s.valid) begin
          load_s = 1'b1;
          sel_s  = tap_wr_s;
        end else begin
          load_s = 1'b0;
        end
        if (is_burst(sel_s.cmd)) load_len_s = BURST_BEATS;
        else                     load_len_s = 4'd1;
        beat_v_s    = load_s;
        beat_acc_s  = sel_s;
        beat_k_s    = 3'd0;
        beat_last_s = load_s & (load_len_s == 4'd1);
        if (load_s && (load_len_s != 4'd1)) state_s = ENG_BURST;
        else                                state_s = ENG_IDLE;
      end
      ENG_BURST: begin
        overlap_s   = tap_rd_s.valid | tap_wr_s.valid;
        beat_v_s    = cur_r.valid;
        beat_acc_s  = cur_r;
        beat_k_s    = beat_idx_r;
        beat_last_s = (beats_left_r == 4'd1);
        if (beats_left_r == 4'd1) state_s = ENG_IDLE;
        else                      state_s = ENG_BURST;
      end
      default: begin
        state_s = ENG_IDLE;
      end
    endcase
  end

  // Beat engine state, current access and beat counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ENG_IDLE;
      cur_r        <= '0;
      beat_idx_r   <= 3'd0;
      beats_left_r <= 4'd0;
    end else begin
      state_r <= state_s;
      if (load_s) begin
        cur_r        <= sel_s;
        beat_idx_r   <= 3'd1;
        beats_left_r <= load_len_s - 4'd1;
      end else if (state_r == ENG_BURST) begin
        cur_r        <= cur_r;
        beat_idx_r   <= beat_idx_r + 3'd1;
        beats_left_r <= beats_left_r - 4'd1;
      end else begin
        cur_r        <= cur_r;
        beat_idx_r   <= beat_idx_r;
        beats_left_r <= beats_left_r;
      end
    end
  end

  // Assemble this cycle's record; fields are zero when no beat is sampled.
  always_comb begin
    pkt_s       = '0;
    beat_mask_s = 10'd0;
    if (beat_v_s) begin
      if (is_burst(beat_acc_s.cmd)) beat_mask_s = BURST_MASK;
      else                          beat_mask_s = 10'd0;
      pkt_s.valid     = 1'b1;
      pkt_s.cmd       = beat_acc_s.cmd;
      pkt_s.bank      = beat_acc_s.bank;
      pkt_s.row       = beat_acc_s.row;
      pkt_s.col       = beat_col(beat_acc_s.col, {7'd0, beat_k_s}, beat_mask_s);
      pkt_s.data      = ddr_dq;
      pkt_s.last      = beat_last_s;
      pkt_s.id        = beat_acc_s.id;
      pkt_s.timestamp = beat_acc_s.timestamp;
    end else begin
      pkt_s = '0;
    end
  end

  // Registered record and error pulse outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_valid       <= 1'b0;
      pkt_cmd         <= 3'd0;
      pkt_bank        <= 2'd0;
      pkt_row         <= 13'd0;
      pkt_col         <= 10'd0;
      pkt_data        <= 16'd0;
      pkt_last        <= 1'b0;
      pkt_id          <= 32'd0;
      pkt_timestamp   <= 32'd0;
      err_closed_bank <= 1'b0;
      err_double_act  <= 1'b0;
      err_overlap     <= 1'b0;
    end else begin
      pkt_valid       <= pkt_s.valid;
      pkt_cmd         <= pkt_s.cmd;
      pkt_bank        <= pkt_s.bank;
      pkt_row         <= pkt_s.row;
      pkt_col         <= pkt_s.col;
      pkt_data        <= pkt_s.data;
      pkt_last        <= pkt_s.last;
      pkt_id          <= pkt_s.id;
      pkt_timestamp   <= pkt_s.timestamp;
      err_closed_bank <= closed_s;
      err_double_act  <= double_act_s;
      err_overlap     <= overlap_s;
    end
  end

endmodule

// File: tb/tb_ddr_bus_decoder.sv
// Self-checking bench for ddr_bus_decoder: directed scenarios plus random
// bus traffic, checked every cycle against a time-based reference model.
module tb_ddr_bus_decoder;
  import ddr_bus_decoder_pkg::*;

  localparam int RD_LAT = 3;
  localparam int WR_LAT = 1;
  localparam int BL     = 8;

  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n;
  logic [1:0]  ddr_ba;
  logic [12:0] ddr_addr;
  logic [15:0] ddr_dq;
  logic        pkt_valid, pkt_last;
  logic [2:0]  pkt_cmd;
  logic [1:0]  pkt_bank;
  logic [12:0] pkt_row;
  logic [9:0]  pkt_col;
  logic [15:0] pkt_data;
  logic [31:0] pkt_id, pkt_timestamp;
  logic        err_closed_bank, err_double_act, err_overlap;

  ddr_bus_decoder #(.RD_LAT(RD_LAT), .WR_LAT(WR_LAT), .BURST_LEN(BL)) dut (
    .clk(clk), .reset_n(reset_n),
    .ddr_cs_n(ddr_cs_n), .ddr_ras_n(ddr_ras_n), .ddr_cas_n(ddr_cas_n), .ddr_we_n(ddr_we_n),
    .ddr_ba(ddr_ba), .ddr_addr(ddr_addr), .ddr_dq(ddr_dq),
    .pkt_valid(pkt_valid), .pkt_cmd(pkt_cmd), .pkt_bank(pkt_bank), .pkt_row(pkt_row),
    .pkt_col(pkt_col), .pkt_data(pkt_data), .pkt_last(pkt_last), .pkt_id(pkt_id),
    .pkt_timestamp(pkt_timestamp), .err_closed_bank(err_closed_bank),
    .err_double_act(err_double_act), .err_overlap(err_overlap)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (model cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit          rd;
    bit          single;
    logic [1:0]  bank;
    logic [12:0] row;
    logic [9:0]  col;
    int unsigned id;
    int unsigned ts;
    int unsigned due;
  } acc_m_t;

  acc_m_t      pend[$];
  bit          m_open[4];
  logic [12:0] m_row[4];
  int unsigned m_id;
  int unsigned cyc;
  acc_m_t      cur;
  longint      start_t, busy_until;

  logic        exp_valid, exp_last, exp_closed, exp_dbl, exp_ovl;
  logic [2:0]  exp_cmd;
  logic [1:0]  exp_bank;
  logic [12:0] exp_row;
  logic [9:0]  exp_col;
  logic [15:0] exp_data;
  logic [31:0] exp_id, exp_ts;

  task automatic clear_exp();
    exp_valid = 0; exp_last = 0; exp_closed = 0; exp_dbl = 0; exp_ovl = 0;
    exp_cmd = 0; exp_bank = 0; exp_row = 0; exp_col = 0; exp_data = 0; exp_id = 0; exp_ts = 0;
  endtask

  task automatic model_reset();
    pend.delete();
    for (int b = 0; b < 4; b++) begin m_open[b] = 0; m_row[b] = 13'd0; end
    m_id = 0; cyc = 0; start_t = 0; busy_until = -1;
    clear_exp();
  endtask

  // Predict the outputs registered by the next clock edge from the driven pins.
  task automatic model_step();
    acc_m_t a, drd, dwr;
    bit rf, wf;
    int L, k, c;
    clear_exp();
    if (!ddr_cs_n) begin
      case ({ddr_ras_n, ddr_cas_n, ddr_we_n})
        3'b011: begin
          if (m_open[ddr_ba]) exp_dbl = 1;
          m_open[ddr_ba] = 1; m_row[ddr_ba] = ddr_addr;
        end
        3'b010: begin
          if (ddr_addr[10]) for (int b = 0; b < 4; b++) m_open[b] = 0;
          else m_open[ddr_ba] = 0;
        end
        3'b101, 3'b100: begin
          if (!m_open[ddr_ba]) exp_closed = 1;
          else begin
            a.rd = ddr_we_n; a.single = ddr_addr[12]; a.bank = ddr_ba;
            a.row = m_row[ddr_ba]; a.col = ddr_addr[9:0]; a.id = m_id; a.ts = cyc;
            a.due = cyc + (a.rd ? RD_LAT : WR_LAT);
            pend.push_back(a); m_id++;
          end
        end
        default: ;
      endcase
    end
    rf = 0; wf = 0;
    for (int i = pend.size() - 1; i >= 0; i--) begin
      if (pend[i].due == cyc) begin
        if (pend[i].rd) begin rf = 1; drd = pend[i]; end
        else begin wf = 1; dwr = pend[i]; end
        pend.delete(i);
      end
    end
    if (rf || wf) begin
      if (longint'(cyc) <= busy_until || (rf && wf)) exp_ovl = 1;
      if (longint'(cyc) > busy_until) begin
        cur = rf ? drd : dwr;
        start_t = cyc;
        busy_until = longint'(cyc) + (cur.single ? 1 : BL) - 1;
      end
    end
    if (longint'(cyc) >= start_t && longint'(cyc) <= busy_until) begin
      L = cur.single ? 1 : BL;
      k = int'(longint'(cyc) - start_t);
      c = int'(cur.col);
      exp_valid = 1;
      exp_cmd = cur.rd ? (cur.single ? SCR : BLR) : (cur.single ? SCW : BLW);
      exp_bank = cur.bank; exp_row = cur.row;
      exp_col = 10'((c - c % L) + (c % L + k) % L);
      exp_data = ddr_dq; exp_last = (k == L - 1);
      exp_id = cur.id; exp_ts = cur.ts;
    end
    cyc++;
  endtask

  // ---------------- compare process ----------------
  typedef struct {
    logic [2:0]  cmd;
    logic [12:0] row;
    logic [9:0]  col;
    logic [15:0] data;
    logic        last;
    logic [31:0] id;
    logic [31:0] ts;
  } rec_t;

  rec_t rec_q[$];
  bit   chk_en = 0;
  int   n_closed = 0, n_dbl = 0, n_ovl = 0;

  // Check every output against the model shortly after each rising edge.
  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      chk("pkt_valid", pkt_valid, exp_valid);
      chk("err_closed_bank", err_closed_bank, exp_closed);
      chk("err_double_act", err_double_act, exp_dbl);
      chk("err_overlap", err_overlap, exp_ovl);
      if (pkt_valid && exp_valid) begin
        chk("pkt_cmd", pkt_cmd, exp_cmd);
        chk("pkt_bank", pkt_bank, exp_bank);
        chk("pkt_row", pkt_row, exp_row);
        chk("pkt_col", pkt_col, exp_col);
        chk("pkt_data", pkt_data, exp_data);
        chk("pkt_last", pkt_last, exp_last);
        chk("pkt_id", pkt_id, exp_id);
        chk("pkt_timestamp", pkt_timestamp, exp_ts);
      end
      if (pkt_valid) rec_q.push_back('{pkt_cmd, pkt_row, pkt_col, pkt_data, pkt_last, pkt_id, pkt_timestamp});
      if (err_closed_bank) n_closed++;
      if (err_double_act) n_dbl++;
      if (err_overlap) n_ovl++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_cycle(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] addr, input logic [15:0] dq);
    {ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n} = c;
    ddr_ba = ba; ddr_addr = addr; ddr_dq = dq;
    model_step();
    @(negedge clk);
  endtask

  task automatic nop(input int n);
    repeat (n) do_cycle(C_NOP, 2'($urandom), 13'($urandom), 16'($urandom));
  endtask

  function automatic logic [15:0] dq_ramp();
    return 16'h1000 + 16'(cyc - 32'd23);
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, pkt_valid, 0);   chk({tag, "_cmd"}, pkt_cmd, 0);
    chk({tag, "_bank"}, pkt_bank, 0);     chk({tag, "_row"}, pkt_row, 0);
    chk({tag, "_col"}, pkt_col, 0);       chk({tag, "_data"}, pkt_data, 0);
    chk({tag, "_last"}, pkt_last, 0);     chk({tag, "_id"}, pkt_id, 0);
    chk({tag, "_ts"}, pkt_timestamp, 0);  chk({tag, "_errc"}, err_closed_bank, 0);
    chk({tag, "_errd"}, err_double_act, 0); chk({tag, "_erro"}, err_overlap, 0);
  endtask

  logic [9:0] wrap_cols [8];
  int snap, w, r;
  logic [3:0] rc;

  initial begin
    reset_n = 1'b0;
    {ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n} = C_NOP;
    ddr_ba = 2'd0; ddr_addr = 13'd0; ddr_dq = 16'd0;
    model_reset();
    #1;
    check_zero("rst_init");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    chk_en = 1;

    // Burst read: ACTIVATE at cycle 5, READ at cycle 20, ramp data from 23.
    rec_q.delete();
    for (int i = 0; i < 34; i++) begin
      if (i == 5)       do_cycle(C_ACT, 2'd1, 13'h0ABC, dq_ramp());
      else if (i == 20) do_cycle(C_RD, 2'd1, 13'h0010, dq_ramp());
      else              do_cycle(C_NOP, 2'd0, 13'h0000, dq_ramp());
    end
    chk("p1_count", rec_q.size(), 8);
    if (rec_q.size() >= 8) begin
      chk("p1_cmd", rec_q[0].cmd, BLR);     chk("p1_row", rec_q[0].row, 13'h0ABC);
      chk("p1_col0", rec_q[0].col, 10'h010); chk("p1_data0", rec_q[0].data, 16'h1000);
      chk("p1_id", rec_q[0].id, 0);          chk("p1_ts", rec_q[0].ts, 20);
      chk("p1_last0", rec_q[0].last, 0);     chk("p1_col7", rec_q[7].col, 10'h017);
      chk("p1_data7", rec_q[7].data, 16'h1007); chk("p1_last7", rec_q[7].last, 1);
    end

    // Wrapping burst write, then a single write.
    rec_q.delete();
    wrap_cols = '{10'h00D, 10'h00E, 10'h00F, 10'h008, 10'h009, 10'h00A, 10'h00B, 10'h00C};
    do_cycle(C_WR, 2'd1, 13'h000D, 16'($urandom));
    nop(12);
    do_cycle(C_WR, 2'd1, 13'h1005, 16'($urandom));
    nop(5);
    chk("p2_count", rec_q.size(), 9);
    if (rec_q.size() >= 9) begin
      for (int i = 0; i < 8; i++) chk("p2_wrap_col", rec_q[i].col, wrap_cols[i]);
      chk("p2_single_cmd", rec_q[8].cmd, SCW); chk("p2_single_last", rec_q[8].last, 1);
      chk("p2_single_col", rec_q[8].col, 10'h005); chk("p2_single_id", rec_q[8].id, 2);
    end

    // Read to a never-activated bank, then a good read keeps the id sequence.
    rec_q.delete();
    snap = n_closed;
    do_cycle(C_RD, 2'd2, 13'h0020, 16'($urandom));
    nop(12);
    chk("p3_no_records", rec_q.size(), 0);
    chk("p3_closed_pulse", n_closed - snap, 1);
    do_cycle(C_RD, 2'd1, 13'h0020, 16'($urandom));
    nop(12);
    chk("p3_next_id", (rec_q.size() > 0) ? rec_q[0].id : 32'hFFFF_FFFF, 3);

    // Double ACTIVATE, then precharge-all followed by a read to bank 0.
    snap = n_dbl;
    do_cycle(C_ACT, 2'd0, 13'h0111, 16'($urandom));
    do_cycle(C_ACT, 2'd0, 13'h0222, 16'($urandom));
    nop(2);
    chk("p4_double_act", n_dbl - snap, 1);
    snap = n_closed;
    do_cycle(C_PRE, 2'd0, 13'h0400, 16'($urandom));
    do_cycle(C_RD, 2'd0, 13'h0000, 16'($urandom));
    nop(12);
    chk("p4_closed_after_pre_all", n_closed - snap, 1);

    // Back-to-back bursts, then a read/write tap collision.
    do_cycle(C_ACT, 2'd1, 13'h0123, 16'($urandom));
    nop(2);
    rec_q.delete();
    do_cycle(C_RD, 2'd1, 13'h0000, 16'($urandom));
    nop(7);
    do_cycle(C_RD, 2'd1, 13'h0008, 16'($urandom));
    nop(14);
    chk("p5_b2b_count", rec_q.size(), 16);
    if (rec_q.size() >= 16) begin
      chk("p5_id_first", rec_q[7].id, 4); chk("p5_id_second", rec_q[8].id, 5);
    end
    rec_q.delete();
    snap = n_ovl;
    do_cycle(C_RD, 2'd1, 13'h0000, 16'($urandom));
    nop(1);
    do_cycle(C_WR, 2'd1, 13'h0000, 16'($urandom));
    nop(12);
    chk("p5_overlap_pulse", n_ovl - snap, 1);
    chk("p5_overlap_count", rec_q.size(), 8);
    if (rec_q.size() >= 8) chk("p5_survivor_cmd", rec_q[7].cmd, BLR);

    // Reset in the middle of a burst.
    rec_q.delete();
    do_cycle(C_RD, 2'd1, 13'h0030, 16'($urandom));
    w = 0;
    while (rec_q.size() < 4 && w < 20) begin nop(1); w++; end
    chk("p6_beats_before_reset", rec_q.size(), 4);
    #2;
    chk_en = 0;
    reset_n = 1'b0;
    #1;
    check_zero("rst_mid");
    repeat (3) @(negedge clk);
    model_reset();
    reset_n = 1'b1;
    chk_en = 1;
    rec_q.delete();
    nop(10);
    chk("p6_no_records", rec_q.size(), 0);
    do_cycle(C_ACT, 2'd3, 13'h1FFF, 16'($urandom));
    nop(1);
    do_cycle(C_RD, 2'd3, 13'h13FF, 16'($urandom));
    nop(6);
    chk("p6_new_count", rec_q.size(), 1);
    chk("p6_new_id", (rec_q.size() > 0) ? rec_q[0].id : 32'hFFFF_FFFF, 0);
    chk("p6_new_ts", (rec_q.size() > 0) ? rec_q[0].ts : 32'hFFFF_FFFF, 12);

    // Random bus traffic.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 50)      rc = C_NOP;
      else if (r < 60) rc = C_ACT;
      else if (r < 64) rc = C_PRE;
      else if (r < 80) rc = C_RD;
      else if (r < 94) rc = C_WR;
      else             rc = 4'($urandom);
      do_cycle(rc, 2'($urandom), 13'($urandom), 16'($urandom));
    end
    nop(16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
